// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of an async FIFO between
// NUM_REQ requesters. Grants rotate round-robin, each grant is limited to
// BURST_MAX beats, and the write strobe is gated by the FIFO full flag so the
// write pointer never advances while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  input  logic                          wfull_i,
  output logic                          winc_o,
  output logic [DATA_WIDTH-1:0]         wdata_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_owner_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               winc;
  logic               last_beat;

  // Round-robin pick: first set request scanning last_owner+1, +2, ... (mod NUM_REQ).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    // Scan from the farthest candidate down so the nearest one wins last.
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner_q) + k) % NUM_REQ;
      if (req_i[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  // Write strobe, acknowledge and data steering for the current owner.
  always_comb begin
    owner_req = req_i[owner_q];
    // Reset wins over an in-flight beat so the pointer never moves in a reset cycle.
    winc      = (state_q == BURST) && owner_req && !wfull_i && !rst;
    last_beat = winc && (beat_cnt_q == CNT_W'(BURST_MAX - 1));
    ack_o     = grant_q & {NUM_REQ{winc}};
    wdata_o   = '0;
    if (grant_q != '0) begin
      wdata_o = req_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign winc_o  = winc;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == BURST);

  // Arbitration FSM: IDLE picks an owner, BURST streams beats until release.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (pick_valid) begin
            state_q  <= BURST;
            owner_q  <= pick_idx;
            grant_q  <= NUM_REQ'(1) << pick_idx;
          end
        end
        BURST: begin
          if (!owner_req || last_beat) begin
            // Release; the following IDLE cycle is the arbitration bubble.
            state_q      <= IDLE;
            grant_q      <= '0;
            last_owner_q <= owner_q;
            beat_cnt_q   <= '0;
          end else if (winc) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant rotation, burst length, full
// stalls, early release and mid-burst reset, plus a short random sweep of the
// write-strobe invariants.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_MAX  = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;

  int n_cmp = 0;
  int n_err = 0;
  int winc_cnt;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_MAX  (BURST_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack),
    .grant_o    (grant),
    .busy_o     (busy),
    .wfull_i    (wfull),
    .winc_o     (winc),
    .wdata_o    (wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester i presents 8'hA0 + 8'h11*i.
  function automatic logic [7:0] dat(input int i);
    return 8'(8'hA0 + 8'h11 * i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one cycle's outputs against the expected owner/strobe, then advance.
  task automatic expect_cycle(input string tag, input logic [3:0] g, input logic w,
                              input logic [7:0] d);
    #1;
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".winc"},  32'(winc),  32'(w));
    check({tag, ".ack"},   32'(ack),   32'(w ? g : 4'b0000));
    check({tag, ".wdata"}, 32'(wdata), 32'(d));
    check({tag, ".busy"},  32'(busy),  32'(g != 4'b0000));
    if (winc) winc_cnt++;
    tick();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    wfull = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    winc_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = dat(i);
    rst = 1'b1;
    req = '0;
    wfull = 1'b0;
    winc_cnt = 0;

    // Reset state.
    do_reset();
    #1;
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.busy",  32'(busy),  32'h0);
    check("rst.winc",  32'(winc),  32'h0);
    check("rst.ack",   32'(ack),   32'h0);

    // 1: single requester, full burst, bubble, re-grant.
    do_reset();
    req = 4'b0001;
    expect_cycle("t1.idle", 4'b0000, 1'b0, 8'h00);
    for (int b = 0; b < BURST_MAX; b++) expect_cycle("t1.beat", 4'b0001, 1'b1, dat(0));
    expect_cycle("t1.bubble", 4'b0000, 1'b0, 8'h00);
    expect_cycle("t1.regrant", 4'b0001, 1'b1, dat(0));
    check("t1.count", 32'(winc_cnt), 32'd5);

    // 2: all requesting, strict rotation with one-cycle bubbles.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_cycle("t2.bubble", 4'b0000, 1'b0, 8'h00);
      for (int b = 0; b < BURST_MAX; b++)
        expect_cycle("t2.beat", 4'(1 << (g % NUM_REQ)), 1'b1, dat(g % NUM_REQ));
    end

    // 3: wfull stalls the burst after beat 2 for 5 cycles.
    do_reset();
    req = 4'b0001;
    expect_cycle("t3.idle", 4'b0000, 1'b0, 8'h00);
    expect_cycle("t3.beat1", 4'b0001, 1'b1, dat(0));
    expect_cycle("t3.beat2", 4'b0001, 1'b1, dat(0));
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) expect_cycle("t3.stall", 4'b0001, 1'b0, dat(0));
    wfull = 1'b0;
    expect_cycle("t3.beat3", 4'b0001, 1'b1, dat(0));
    expect_cycle("t3.beat4", 4'b0001, 1'b1, dat(0));
    expect_cycle("t3.release", 4'b0000, 1'b0, 8'h00);
    check("t3.count", 32'(winc_cnt), 32'd4);

    // 4: owner drops req after 2 beats; index 0 then loses to index 1.
    do_reset();
    req = 4'b0001;
    expect_cycle("t4.idle", 4'b0000, 1'b0, 8'h00);
    expect_cycle("t4.beat1", 4'b0001, 1'b1, dat(0));
    expect_cycle("t4.beat2", 4'b0001, 1'b1, dat(0));
    req = 4'b0000;
    expect_cycle("t4.drop", 4'b0001, 1'b0, dat(0));
    req = 4'b0011;
    expect_cycle("t4.bubble", 4'b0000, 1'b0, 8'h00);
    check("t4.count", 32'(winc_cnt), 32'd2);
    expect_cycle("t4.next", 4'b0010, 1'b1, dat(1));

    // 5: reset during beat 2 blocks the strobe and clears the grant.
    do_reset();
    req = 4'b0101;
    expect_cycle("t5.idle", 4'b0000, 1'b0, 8'h00);
    expect_cycle("t5.beat1", 4'b0001, 1'b1, dat(0));
    rst = 1'b1;
    #1;
    check("t5.rst_winc", 32'(winc), 32'h0);
    check("t5.rst_ack",  32'(ack),  32'h0);
    tick();
    rst = 1'b0;
    expect_cycle("t5.after", 4'b0000, 1'b0, 8'h00);
    expect_cycle("t5.regrant", 4'b0001, 1'b1, dat(0));

    // Random sweep: strobe never fires on full, grant stays one-hot or empty.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom);
      wfull = ($urandom_range(0, 3) == 0);
      #1;
      check("rnd.no_winc_full", 32'(winc & wfull), 32'h0);
      check("rnd.onehot", 32'($countones(grant) <= 1), 32'h1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
